// File: rtl/trading_logic_scheduler.sv
// trading_logic_scheduler: per-stock latest-wins update slots feeding one shared trading_logic pipeline.
// Latency: an update written at edge t is pending in cycle t+1 and can issue in cycle t+2 at the earliest.
// Backpressure: issues are spaced at least ISSUE_GAP cycles apart and stop while MAX_INFLIGHT results are outstanding.
//   While issuing is stalled, new updates overwrite the pending slot contents.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_upd_*               market update strobe, stock id and payload (ask, bid, time, inventory)
//   i_tl_done             one result returned by trading_logic (its o_data_valid)
//   o_tl_*                registered issue to trading_logic; o_tl_data_valid is a one-cycle pulse
//   o_pending             per-stock pending flags
//   o_inflight            issued-but-not-returned count
//   o_busy                any slot pending, or any request in flight
//   o_underflow           sticky: a result returned while nothing was in flight
//   o_coalesce_count      count of overwrites of a pending slot
//
// Optional feature: define TL_SCHED_COALESCE_STATS_EN to build the saturating
// coalesce counter. When it is undefined, o_coalesce_count is tied to 0.

module trading_logic_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int FP_WORD_SIZE = 64,
  parameter int NUM_STOCKS   = 4,
  parameter int ISSUE_GAP    = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_upd_valid,
  input  logic [$clog2(NUM_STOCKS)-1:0]      i_upd_stock_id,
  input  logic [DATA_WIDTH-1:0]              i_best_ask,
  input  logic [DATA_WIDTH-1:0]              i_best_bid,
  input  logic [FP_WORD_SIZE-1:0]            i_curr_time,
  input  logic [FP_WORD_SIZE-1:0]            i_inventory_state,
  input  logic                               i_tl_done,
  output logic [DATA_WIDTH-1:0]              o_tl_best_ask,
  output logic [DATA_WIDTH-1:0]              o_tl_best_bid,
  output logic [FP_WORD_SIZE-1:0]            o_tl_curr_time,
  output logic [FP_WORD_SIZE-1:0]            o_tl_inventory_state,
  output logic [$clog2(NUM_STOCKS)-1:0]      o_tl_stock_id,
  output logic                               o_tl_data_valid,
  output logic [NUM_STOCKS-1:0]              o_pending,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  o_inflight,
  output logic                               o_busy,
  output logic                               o_underflow,
  output logic [15:0]                        o_coalesce_count
);

  localparam int SW = $clog2(NUM_STOCKS);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int GW = $clog2(ISSUE_GAP + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   ask;
    logic [DATA_WIDTH-1:0]   bid;
    logic [FP_WORD_SIZE-1:0] tm;
    logic [FP_WORD_SIZE-1:0] inv;
  } slot_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  slot_t                 slot [NUM_STOCKS];
  slot_t                 upd_dat;
  logic [NUM_STOCKS-1:0] pending;
  logic [NUM_STOCKS-1:0] pending_next;
  logic [SW-1:0]         ptr;
  logic [SW-1:0]         sel;
  logic [SW-1:0]         probe;
  logic                  sel_found;
  logic                  issue;
  state_t                state;
  logic [GW-1:0]         gap_cnt;
  logic [IW-1:0]         inflight;

  assign upd_dat = '{ask: i_best_ask, bid: i_best_bid, tm: i_curr_time, inv: i_inventory_state};

  // Round-robin pick: first pending stock at ptr, ptr+1, ... Indices wrap
  // naturally because NUM_STOCKS is a power of two.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    probe     = '0;
    for (int i = 0; i < NUM_STOCKS; i++) begin
      probe = ptr + SW'(i);
      if (!sel_found && pending[probe]) begin
        sel       = probe;
        sel_found = 1'b1;
      end
    end
  end

  assign issue = (state == IDLE) && sel_found && (inflight < IW'(MAX_INFLIGHT));

  // The write is applied after the issue clear, so a same-cycle write to the
  // slot being issued leaves it pending with the new contents.
  always_comb begin
    pending_next = pending;
    if (issue) begin
      pending_next[sel] = 1'b0;
    end
    if (i_upd_valid) begin
      pending_next[i_upd_stock_id] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_STOCKS; i++) begin
        slot[i] <= '0;
      end
      pending              <= '0;
      ptr                  <= '0;
      state                <= IDLE;
      gap_cnt              <= '0;
      inflight             <= '0;
      o_underflow          <= 1'b0;
      o_tl_data_valid      <= 1'b0;
      o_tl_best_ask        <= '0;
      o_tl_best_bid        <= '0;
      o_tl_curr_time       <= '0;
      o_tl_inventory_state <= '0;
      o_tl_stock_id        <= '0;
    end else begin
      pending         <= pending_next;
      o_tl_data_valid <= issue;

      if (i_upd_valid) begin
        slot[i_upd_stock_id] <= upd_dat;
      end

      // The issue reads the registered slot, so it carries the old contents
      // even when the same slot is written this cycle.
      if (issue) begin
        o_tl_best_ask        <= slot[sel].ask;
        o_tl_best_bid        <= slot[sel].bid;
        o_tl_curr_time       <= slot[sel].tm;
        o_tl_inventory_state <= slot[sel].inv;
        o_tl_stock_id        <= sel;
        ptr                  <= sel + SW'(1);
      end

      case (state)
        IDLE: begin
          // With ISSUE_GAP == 1 the FSM stays here and can issue every cycle.
          if (issue && (ISSUE_GAP > 1)) begin
            state   <= GAP;
            gap_cnt <= GW'(ISSUE_GAP - 1);
          end
        end
        GAP: begin
          if (gap_cnt <= GW'(1)) begin
            state <= IDLE;
          end
          gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= IDLE;
      endcase

      // A return coinciding with an issue cancels out; a return with nothing
      // outstanding is recorded and otherwise ignored.
      if (issue && !i_tl_done) begin
        inflight <= inflight + IW'(1);
      end else if (!issue && i_tl_done && (inflight != '0)) begin
        inflight <= inflight - IW'(1);
      end
      if (i_tl_done && (inflight == '0)) begin
        o_underflow <= 1'b1;
      end
    end
  end

  assign o_pending  = pending;
  assign o_inflight = inflight;
  assign o_busy     = (|pending) || (inflight != '0);

`ifdef TL_SCHED_COALESCE_STATS_EN
  logic coalesce_hit;

  // An overwrite counts only if the old contents are lost without being issued.
  assign coalesce_hit = i_upd_valid && pending[i_upd_stock_id] &&
                        !(issue && (sel == i_upd_stock_id));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_coalesce_count <= '0;
    end else if (coalesce_hit && (o_coalesce_count != 16'hFFFF)) begin
      o_coalesce_count <= o_coalesce_count + 16'd1;
    end
  end
`else
  assign o_coalesce_count = 16'd0;
`endif

endmodule

// File: tb/tb_trading_logic_scheduler.sv
// Directed bench for trading_logic_scheduler: a scoreboard queue holds the
// expected issues in order and a negedge monitor pops and compares each one.
module tb_trading_logic_scheduler;

  localparam int DW = 32;
  localparam int FW = 64;
  localparam int NS = 4;
  localparam int GAPC = 4;
  localparam int MAXF = 2;

`ifdef TL_SCHED_COALESCE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int          stock;
    logic [31:0] ask;
    logic [31:0] bid;
    logic [63:0] tm;
    logic [63:0] inv;
  } exp_t;

  logic          clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_upd_valid = 1'b0;
  logic [1:0]    i_upd_stock_id = '0;
  logic [DW-1:0] i_best_ask = '0;
  logic [DW-1:0] i_best_bid = '0;
  logic [FW-1:0] i_curr_time = '0;
  logic [FW-1:0] i_inventory_state = '0;
  logic          i_tl_done = 1'b0;
  logic [DW-1:0] o_tl_best_ask;
  logic [DW-1:0] o_tl_best_bid;
  logic [FW-1:0] o_tl_curr_time;
  logic [FW-1:0] o_tl_inventory_state;
  logic [1:0]    o_tl_stock_id;
  logic          o_tl_data_valid;
  logic [NS-1:0] o_pending;
  logic [1:0]    o_inflight;
  logic          o_busy;
  logic          o_underflow;
  logic [15:0]   o_coalesce_count;

  exp_t sb[$];
  int   issue_cyc[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   auto_done = 1'b0;

  trading_logic_scheduler #(
    .DATA_WIDTH(DW), .FP_WORD_SIZE(FW), .NUM_STOCKS(NS),
    .ISSUE_GAP(GAPC), .MAX_INFLIGHT(MAXF)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_upd_valid(i_upd_valid), .i_upd_stock_id(i_upd_stock_id),
    .i_best_ask(i_best_ask), .i_best_bid(i_best_bid),
    .i_curr_time(i_curr_time), .i_inventory_state(i_inventory_state),
    .i_tl_done(i_tl_done),
    .o_tl_best_ask(o_tl_best_ask), .o_tl_best_bid(o_tl_best_bid),
    .o_tl_curr_time(o_tl_curr_time), .o_tl_inventory_state(o_tl_inventory_state),
    .o_tl_stock_id(o_tl_stock_id), .o_tl_data_valid(o_tl_data_valid),
    .o_pending(o_pending), .o_inflight(o_inflight), .o_busy(o_busy),
    .o_underflow(o_underflow), .o_coalesce_count(o_coalesce_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every issue pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (o_tl_data_valid === 1'b1) begin
      issue_cyc.push_back(cyc);
      check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("issue_stock", 64'(o_tl_stock_id), 64'(e.stock));
        check("issue_ask", 64'(o_tl_best_ask), 64'(e.ask));
        check("issue_bid", 64'(o_tl_best_bid), 64'(e.bid));
        check("issue_time", o_tl_curr_time, e.tm);
        check("issue_inv", o_tl_inventory_state, e.inv);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock; optionally return a result for an issue seen this cycle.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      i_tl_done = auto_done & o_tl_data_valid;
      tick();
      i_tl_done = 1'b0;
    end
  endtask

  task automatic write(input int s, input logic [31:0] a, input logic [31:0] b);
    i_upd_valid       = 1'b1;
    i_upd_stock_id    = 2'(s);
    i_best_ask        = a;
    i_best_bid        = b;
    i_curr_time       = 64'h0000_1000_0000_0000 + 64'(a);
    i_inventory_state = {32'hABCD_0000 + 32'(s), a};
    i_tl_done         = auto_done & o_tl_data_valid;
    tick();
    i_upd_valid = 1'b0;
    i_tl_done   = 1'b0;
  endtask

  task automatic expect_issue(input int s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.stock = s;
    e.ask   = a;
    e.bid   = b;
    e.tm    = 64'h0000_1000_0000_0000 + 64'(a);
    e.inv   = {32'hABCD_0000 + 32'(s), a};
    sb.push_back(e);
  endtask

  task automatic pulse_done();
    i_tl_done = 1'b1;
    tick();
    i_tl_done = 1'b0;
  endtask

  initial begin
    // Reset and idle state
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    check("rst_valid", 64'(o_tl_data_valid), 64'd0);
    check("rst_pending", 64'(o_pending), 64'd0);
    check("rst_inflight", 64'(o_inflight), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_underflow", 64'(o_underflow), 64'd0);
    check("rst_coalesce", 64'(o_coalesce_count), 64'd0);
    check("rst_ask", 64'(o_tl_best_ask), 64'd0);
    check("rst_stock", 64'(o_tl_stock_id), 64'd0);

    // Single update: issue two cycles after the write edge
    expect_issue(2, 100, 98);
    write(2, 100, 98);
    check("single_pending", 64'(o_pending), 64'b0100);
    check("single_valid_early", 64'(o_tl_data_valid), 64'd0);
    tick();
    check("single_valid", 64'(o_tl_data_valid), 64'd1);
    check("single_inflight", 64'(o_inflight), 64'd1);
    check("single_busy", 64'(o_busy), 64'd1);
    tick();
    check("single_pulse_end", 64'(o_tl_data_valid), 64'd0);
    check("hold_ask", 64'(o_tl_best_ask), 64'd100);
    pulse_done();
    check("single_returned", 64'(o_inflight), 64'd0);
    step(6);
    check("single_idle_busy", 64'(o_busy), 64'd0);

    // Round-robin: 0,1,3 issue 4 cycles apart; a later 0 waits behind 3
    auto_done = 1'b1;
    issue_cyc.delete();
    expect_issue(0, 200, 199);
    expect_issue(1, 210, 209);
    expect_issue(3, 230, 229);
    expect_issue(0, 201, 198);
    write(0, 200, 199);
    write(1, 210, 209);
    write(3, 230, 229);
    step(3);
    write(0, 201, 198);
    step(12);
    check("rr_count", 64'(issue_cyc.size()), 64'd4);
    for (int k = 1; k < 4; k++) begin
      if (issue_cyc.size() > k)
        check($sformatf("rr_spacing%0d", k), 64'(issue_cyc[k] - issue_cyc[k-1]), 64'd4);
    end
    check("rr_inflight", 64'(o_inflight), 64'd0);

    // Coalesce: three writes to stock 1 while the FSM is in GAP
    expect_issue(2, 300, 290);
    expect_issue(1, 12, 9);
    write(2, 300, 290);
    write(1, 10, 7);
    write(1, 11, 8);
    write(1, 12, 9);
    step(10);
    check("coalesce_count", 64'(o_coalesce_count), STATS ? 64'd2 : 64'd0);
    check("coalesce_sb_empty", 64'(sb.size()), 64'd0);

    // Inflight cap of 2: two issues then stall; stalled slot keeps coalescing
    auto_done = 1'b0;
    issue_cyc.delete();
    expect_issue(0, 400, 399);
    expect_issue(1, 410, 409);
    write(0, 400, 399);
    write(1, 410, 409);
    write(2, 420, 419);
    write(3, 430, 429);
    step(10);
    check("cap_issues", 64'(issue_cyc.size()), 64'd2);
    check("cap_inflight", 64'(o_inflight), 64'd2);
    check("cap_pending", 64'(o_pending), 64'b1100);
    expect_issue(2, 420, 419);
    expect_issue(3, 333, 332);
    write(3, 333, 332);
    check("cap_coalesce", 64'(o_coalesce_count), STATS ? 64'd3 : 64'd0);
    pulse_done();
    step(8);
    check("cap_one_more", 64'(issue_cyc.size()), 64'd3);
    check("cap_inflight2", 64'(o_inflight), 64'd2);
    check("cap_pending2", 64'(o_pending), 64'b1000);
    pulse_done();
    pulse_done();
    auto_done = 1'b1;
    step(10);
    check("cap_drained", 64'(issue_cyc.size()), 64'd4);
    check("cap_inflight0", 64'(o_inflight), 64'd0);

    // Same-slot write during issue, and return coincident with an issue
    auto_done = 1'b0;
    expect_issue(0, 40, 39);
    expect_issue(0, 50, 49);
    write(0, 40, 39);
    write(0, 50, 49);
    check("same_valid", 64'(o_tl_data_valid), 64'd1);
    check("same_pending", 64'(o_pending), 64'b0001);
    check("same_inflight", 64'(o_inflight), 64'd1);
    step(3);
    pulse_done();
    check("coinc_valid", 64'(o_tl_data_valid), 64'd1);
    check("coinc_inflight", 64'(o_inflight), 64'd1);
    check("coinc_pending", 64'(o_pending), 64'd0);
    check("same_no_coalesce", 64'(o_coalesce_count), STATS ? 64'd3 : 64'd0);
    pulse_done();
    step(6);
    check("same_inflight0", 64'(o_inflight), 64'd0);

    // Underflow, then reset during GAP with slots pending
    pulse_done();
    check("underflow_set", 64'(o_underflow), 64'd1);
    check("underflow_inflight", 64'(o_inflight), 64'd0);
    issue_cyc.delete();
    expect_issue(1, 500, 499);
    write(1, 500, 499);
    write(2, 510, 509);
    write(3, 520, 519);
    check("pre_rst_busy", 64'(o_busy), 64'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("mid_rst_valid", 64'(o_tl_data_valid), 64'd0);
    check("mid_rst_pending", 64'(o_pending), 64'd0);
    check("mid_rst_inflight", 64'(o_inflight), 64'd0);
    check("mid_rst_underflow", 64'(o_underflow), 64'd0);
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_ask", 64'(o_tl_best_ask), 64'd0);
    check("mid_rst_stock", 64'(o_tl_stock_id), 64'd0);
    check("mid_rst_coalesce", 64'(o_coalesce_count), 64'd0);
    step(10);
    check("mid_rst_no_issue", 64'(issue_cyc.size()), 64'd1);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
